// File: rtl/token_pkg.sv
// Shared constants and width helper for the serial token chain stages.
package token_pkg;

  localparam int unsigned TOK_DEFAULT_FACTOR = 2;
  localparam int unsigned TOK_DEFAULT_MAX    = 100;

  function automatic int unsigned tok_cnt_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/multiply_tokens_if.sv
// Token stream and status bundle between a token producer/consumer and multiply_tokens.
interface multiply_tokens_if #(
  parameter int unsigned CNT_W = 7
);
  logic             a;
  logic             b_ready;
  logic             ovf_clr;
  logic             b;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  modport master (output a, b_ready, ovf_clr, input b, pending, overflow);
  modport slave  (input a, b_ready, ovf_clr, output b, pending, overflow);
endinterface

// File: rtl/sat_updown_counter.sv
// Up/down counter that clips at MAX and flags the cycle in which clipping happens.
module sat_updown_counter #(
  parameter int unsigned W   = 7,
  parameter int unsigned MAX = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_event
);

  logic [W:0] sum;

  // One extra bit keeps count+inc from wrapping; dec is ignored at zero so the
  // subtraction can never underflow into a false saturation.
  always_comb begin
    sum       = {1'b0, count} + {1'b0, inc} - {{W{1'b0}}, (dec && (count != '0))};
    sat_event = (sum > (W+1)'(MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (sat_event) begin
      count <= W'(MAX);
    end else begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/multiply_tokens.sv
// Serial token expander: each input token becomes FACTOR output tokens, buffered
// in a saturating backlog with backpressure and a sticky overflow flag.
module multiply_tokens
  import token_pkg::*;
#(
  parameter int unsigned FACTOR      = TOK_DEFAULT_FACTOR,
  parameter int unsigned MAX_PENDING = TOK_DEFAULT_MAX
) (
  input  logic                clk,
  input  logic                rst,
  multiply_tokens_if.slave    tok
);

  localparam int unsigned CNT_W = tok_cnt_w(MAX_PENDING);

  if (FACTOR < 1) begin : g_bad_factor
    $fatal(1, "multiply_tokens: FACTOR must be >= 1");
  end
  if (MAX_PENDING < FACTOR) begin : g_bad_max
    $fatal(1, "multiply_tokens: MAX_PENDING must be >= FACTOR");
  end
  if ($bits(tok.pending) != CNT_W) begin : g_bad_if
    $fatal(1, "multiply_tokens: interface CNT_W does not match MAX_PENDING");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] add;
  logic             take;
  logic             sat;
  logic             ovf;

  always_comb begin
    add  = tok.a ? CNT_W'(FACTOR) : '0;
    take = (cnt != '0) && tok.b_ready;
  end

  sat_updown_counter #(
    .W   (CNT_W),
    .MAX (MAX_PENDING)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (add),
    .dec       (take),
    .count     (cnt),
    .sat_event (sat)
  );

  // A saturation in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (sat) begin
      ovf <= 1'b1;
    end else if (tok.ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign tok.b        = (cnt != '0);
  assign tok.pending  = cnt;
  assign tok.overflow = ovf;

endmodule
